// File: rtl/des_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_pkg                                                              |
// | Shared state encoding and key-schedule shift tables for DES control. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package des_pkg;

    localparam int NUM_ROUNDS_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_FINAL  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam logic [1:0] C_ENC_SHIFT [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [1:0] enc_shift(input logic [3:0] idx);
        return C_ENC_SHIFT[idx];
    endfunction

    // Decrypt walks the encrypt schedule backwards: entry i uses enc[16-i],
    // and round 0 starts from the unrotated C16/D16 (== C0/D0).
    function automatic logic [1:0] dec_shift(input logic [3:0] idx);
        logic [3:0] w_rev;
        w_rev = 4'd0 - idx;
        return (idx == 4'd0) ? 2'd0 : C_ENC_SHIFT[w_rev];
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_shift_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_shift_lut                                                        |
// | Per-round C/D rotate amount for encrypt or decrypt; 0 when disabled. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module des_shift_lut
    import des_pkg::*;
#(
    parameter int ROUND_W = 4
) (
    input  logic [ROUND_W-1:0] round_i,
    input  logic               decrypt_i,
    input  logic               en_i,
    output logic [1:0]         shift_amt_o
);

    logic [3:0] w_idx;

    always_comb begin
        w_idx       = 4'(round_i);
        shift_amt_o = 2'd0;
        if (en_i) begin
            shift_amt_o = decrypt_i ? dec_shift(w_idx) : enc_shift(w_idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/des_round_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_round_scheduler                                                  |
// | Control FSM sequencing load, 16 rounds, final permutation, output.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module des_round_scheduler
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
    parameter int ROUND_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               decrypt_i,
    input  logic               flush_i,
    output logic               load_o,
    output logic               round_en_o,
    output logic [ROUND_W-1:0] round_o,
    output logic [1:0]         shift_amt_o,
    output logic               shift_dir_o,
    output logic               final_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o
);

    state_t               r_state;
    state_t               w_state_next;
    logic [ROUND_W-1:0]   r_cnt;
    logic [ROUND_W-1:0]   w_cnt_next;
    logic                 r_mode;
    logic                 w_mode_next;
    logic                 w_accept;

    // The result register may be drained in the same cycle L/R is reloaded,
    // so OUTPUT can hand straight over to a new block.
    assign in_ready_o  = !rst_i && !flush_i &&
                         ((r_state == ST_IDLE) || ((r_state == ST_OUTPUT) && out_ready_i));
    assign w_accept    = in_valid_i && in_ready_o;

    assign load_o      = w_accept;
    assign round_en_o  = !rst_i && (r_state == ST_ROUND);
    assign round_o     = rst_i ? '0 : r_cnt;
    assign final_o     = !rst_i && (r_state == ST_FINAL);
    assign out_valid_o = !rst_i && (r_state == ST_OUTPUT);
    assign busy_o      = !rst_i && (r_state != ST_IDLE);
    assign shift_dir_o = busy_o && r_mode;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mode_next  = r_mode;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ROUND;
                    w_cnt_next   = '0;
                    w_mode_next  = decrypt_i;
                end
            end
            ST_ROUND: begin
                if (r_cnt == ROUND_W'(NUM_ROUNDS - 1)) begin
                    w_state_next = ST_FINAL;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + ROUND_W'(1);
                end
            end
            ST_FINAL: begin
                w_state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready_i) begin
                    if (w_accept) begin
                        w_state_next = ST_ROUND;
                        w_cnt_next   = '0;
                        w_mode_next  = decrypt_i;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        if (flush_i) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_mode  <= w_mode_next;
        end
    end

    des_shift_lut #(
        .ROUND_W (ROUND_W)
    ) u_shift_lut (
        .round_i     (round_o),
        .decrypt_i   (r_mode),
        .en_i        (round_en_o),
        .shift_amt_o (shift_amt_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i && round_en_o) begin
            assert (int'(round_o) < NUM_ROUNDS);
        end
        if (!rst_i) begin
            assert ($onehot0({load_o, round_en_o, final_o}));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_round_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_des_round_scheduler                                               |
// | Scoreboard bench: stimulus queues expected events, monitor pops them.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_des_round_scheduler;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       decrypt_i;
    logic       flush_i;
    logic       load_o;
    logic       round_en_o;
    logic [3:0] round_o;
    logic [1:0] shift_amt_o;
    logic       shift_dir_o;
    logic       final_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       busy_o;

    des_round_scheduler #(
        .NUM_ROUNDS (16),
        .ROUND_W    (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .decrypt_i   (decrypt_i),
        .flush_i     (flush_i),
        .load_o      (load_o),
        .round_en_o  (round_en_o),
        .round_o     (round_o),
        .shift_amt_o (shift_amt_o),
        .shift_dir_o (shift_dir_o),
        .final_o     (final_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 load, 1 round, 2 final, 3 output start
    typedef struct {
        int kind;
        int cycle;
        int rnd;
        int amt;
        int dir;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    int enc_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_tab [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic push_ev(input int k, input int c, input int r, input int a, input int d);
        ev_t e;
        e.kind  = k;
        e.cycle = c;
        e.rnd   = r;
        e.amt   = a;
        e.dir   = d;
        sb.push_back(e);
    endtask

    // Accept at cycle t: rounds at t+1.., final at t+17, output from t+18.
    task automatic push_block(input int dec, input int t, input int nr, input int full);
        push_ev(0, t, 0, 0, 0);
        for (int r = 0; r < nr; r++) begin
            push_ev(1, t + 1 + r, r, (dec != 0) ? dec_tab[r] : enc_tab[r], dec);
        end
        if (full != 0) begin
            push_ev(2, t + 17, 0, 0, 0);
            push_ev(3, t + 18, 0, 0, 0);
        end
    endtask

    task automatic check_ev(input int k, input int r, input int a, input int d);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got kind=%0d cycle=%0d rnd=%0d amt=%0d dir=%0d, nothing expected",
                     k, cyc, r, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cycle != cyc || e.rnd != r || e.amt != a || e.dir != d) begin
                bad++;
                $display("FAIL sb_event got kind=%0d cycle=%0d rnd=%0d amt=%0d dir=%0d want kind=%0d cycle=%0d rnd=%0d amt=%0d dir=%0d",
                         k, cyc, r, a, d, e.kind, e.cycle, e.rnd, e.amt, e.dir);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (out_valid_o && !prev_ov) check_ev(3, 0, 0, 0);
        if (load_o)                  check_ev(0, 0, 0, 0);
        if (round_en_o)              check_ev(1, int'(round_o), int'(shift_amt_o), int'(shift_dir_o));
        if (final_o)                 check_ev(2, 0, 0, 0);
        prev_ov = out_valid_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) step();
    endtask

    function automatic int out_vec();
        return int'({load_o, round_en_o, round_o, shift_amt_o, shift_dir_o,
                     final_o, out_valid_o, busy_o, in_ready_o});
    endfunction

    int t, t2, t3, t4, t5;

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b1;
        decrypt_i   = 1'b1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_outputs", out_vec(), 0);

        step();
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        decrypt_i  = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(in_ready_o), 1);
        chk("idle_busy", int'(busy_o), 0);

        // Encrypt block, then 5 cycles of backpressure with a pending request
        step();
        in_valid_i = 1'b1;
        decrypt_i  = 1'b0;
        t = cyc;
        push_block(0, t, 16, 1);
        step();
        in_valid_i = 1'b0;
        goto_cycle(t + 18);
        in_valid_i = 1'b1;
        decrypt_i  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid_o), 1);
            chk("bp_in_ready", int'(in_ready_o), 0);
            step();
        end

        // Release with a simultaneous decrypt request
        out_ready_i = 1'b1;
        t2 = cyc;
        push_block(1, t2, 16, 1);
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        goto_cycle(t2 + 18);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", int'(out_valid_o), 0);
        chk("drain_busy", int'(busy_o), 0);

        // Flush at round 7, with a request that must be ignored
        step();
        in_valid_i = 1'b1;
        decrypt_i  = 1'b0;
        t3 = cyc;
        push_block(0, t3, 8, 0);
        step();
        in_valid_i = 1'b0;
        goto_cycle(t3 + 8);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", int'(in_ready_o), 0);
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", int'(busy_o), 0);
        chk("flush_out_valid", int'(out_valid_o), 0);

        // Reset where round 3 would be presented
        step();
        in_valid_i = 1'b1;
        decrypt_i  = 1'b0;
        t4 = cyc;
        push_block(0, t4, 3, 0);
        step();
        in_valid_i = 1'b0;
        goto_cycle(t4 + 4);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", out_vec(), 0);
        step();
        step();
        rst_i = 1'b0;

        // in_valid stuck high across three decrypt blocks
        in_valid_i  = 1'b1;
        decrypt_i   = 1'b1;
        out_ready_i = 1'b1;
        t5 = cyc;
        for (int b = 0; b < 3; b++) push_block(1, t5 + 18 * b, 16, 1);
        goto_cycle(t5 + 37);
        in_valid_i = 1'b0;
        goto_cycle(t5 + 60);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("end_busy", int'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_round_scheduler.md
Name: des_round_scheduler

Overview:
Control FSM for the iterative DES datapath. It accepts one 64-bit block request per handshake and sequences 16 round-function cycles. It generates per-round key-schedule shift controls for encrypt and decrypt, then presents the final-permutation result (the datapath's ip_inverse_permutation output) behind a valid/ready output handshake. The block holds no data registers: L/R, C/D and result registers live in the datapath and are steered by this block's outputs.

Parameters:
NUM_ROUNDS, 16, number of round cycles per block; fixed at 16 for DES and kept only for reduced-round debug builds (legal range 2..16).
ROUND_W, 4, width of round index; must satisfy 2**ROUND_W >= NUM_ROUNDS.

Ports:
clk_i  input  1  single clock; all state changes on rising edge.
rst_i  input  1  synchronous, active-high reset.
in_valid_i  input  1  request present (data/key/mode valid at datapath inputs).
in_ready_o  output  1  scheduler can accept a request this cycle.
decrypt_i  input  1  mode of request, sampled on accept (0 = encrypt, 1 = decrypt).
flush_i  input  1  synchronous abort of the current block.
load_o  output  1  datapath loads IP(data) into L/R and PC1(key) into C/D this cycle.
round_en_o  output  1  datapath performs one round this cycle.
round_o  output  ROUND_W  current round index, 0..NUM_ROUNDS-1.
shift_amt_o  output  2  C/D rotate amount this round: 0, 1 or 2.
shift_dir_o  output  1  0 = rotate left (encrypt), 1 = rotate right (decrypt).
final_o  output  1  datapath captures the swapped R16/L16 through the inverse permutation into the result register.
out_valid_o  output  1  result register holds a valid block.
out_ready_i  input  1  consumer accepts the result.
busy_o  output  1  state is not IDLE.

Behaviour:
- States: IDLE, ROUND, FINAL, OUTPUT; 2-bit encoding lives in the shared package.
- Reset, synchronous on clk_i while rst_i=1:
  - state=IDLE, round counter=0, mode register=0.
  - All outputs are 0 during reset, including in_ready_o (gated by rst_i).
- in_ready_o = !rst_i & (state==IDLE | (state==OUTPUT & out_ready_i)).
- Accept = in_valid_i & in_ready_o.
  - load_o = accept (combinational).
  - On accept: mode register <= decrypt_i, counter <= 0, state <= ROUND.
- ROUND state:
  - round_en_o=1 and round_o=counter; counter increments each cycle.
  - When counter==NUM_ROUNDS-1, the next state is FINAL and the counter is cleared.
- Shift table, indexed by round_o:
  - Encrypt: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - shift_amt_o is valid only while round_en_o=1 and is 0 otherwise.
  - shift_dir_o = mode register while busy, 0 in IDLE.
- FINAL state: one cycle with final_o=1, then OUTPUT.
- OUTPUT state: out_valid_o=1, held stable until out_ready_i.
  - out_ready_i with no new accept: go to IDLE.
  - out_ready_i with a simultaneous accept: go straight to ROUND. The result register is consumed in the same cycle the L/R load occurs, which is legal because the result register is separate from L/R.
- Latency: accept at cycle T gives round cycles T+1..T+16, final_o at T+17 and out_valid_o from T+18.
- Throughput: 18 cycles per block with continuous handshakes.
- flush_i has priority over everything except rst_i:
  - Next state IDLE, counter 0; out_valid_o drops the next cycle.
  - flush_i in IDLE is a no-op.
  - An accept in the same cycle as flush_i is ignored (in_ready_o is forced 0 while flush_i=1).
- Counter wrap: the counter never exceeds NUM_ROUNDS-1. An assertion fires if round_o >= NUM_ROUNDS while round_en_o=1.
- Exclusivity: load_o, round_en_o and final_o are mutually exclusive, except that load_o may coincide with out_valid_o in OUTPUT.

Decomposition:
- Package des_pkg holds:
  - the state enum;
  - the NUM_ROUNDS default;
  - the 16-entry encrypt shift table as a constant function/array;
  - the decrypt table derived from it (entry 0 forced to 0, entry i = enc[16-i]).
- Sub-module des_shift_lut (combinational): round index + mode to shift_amt_o. This is natural to isolate so the key-schedule datapath can reuse it. The FSM and counter stay in the top module.

Test Plan:
- Encrypt handshake: in_valid_i=1 with decrypt_i=0 in IDLE -> load_o pulse at T; round_en_o high T+1..T+16 with round_o 0..15; shift_amt_o sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, shift_dir_o=0; final_o at T+17; out_valid_o from T+18.
- Decrypt mode: decrypt_i=1 -> shift_amt_o sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with shift_dir_o=1 throughout.
- End-to-end with datapath: key 133457799BBCDFF1, plaintext 0123456789ABCDEF -> result 85E813540F0AB405; decrypting that result returns the plaintext.
- Backpressure: out_ready_i=0 for 5 cycles in OUTPUT -> out_valid_o held, in_ready_o=0. Raising out_ready_i with in_valid_i=1 -> same-cycle load_o and next cycle round_o=0.
- Flush and reset: flush_i at round_o=7 -> IDLE next cycle, no final_o, busy_o=0. rst_i asserted at round_o=3 -> all outputs 0 during reset, IDLE afterwards, and a new request starts at round_o=0.
- Protocol checks: in_valid_i stuck high over 3 blocks -> exactly one load_o per 18 cycles; mutual-exclusivity assertions never fire.
